// File: rtl/aes128_dec_iter_if.sv
// Request/response bus of the iterative AES-128 decrypt core.
// The master drives ciphertext and key; the slave returns plaintext.
interface aes128_dec_iter_if;
  localparam int unsigned BLK_W = 128;

  logic             in_valid;
  logic             in_ready;
  logic [BLK_W-1:0] key;
  logic [BLK_W-1:0] ct;
  logic             out_valid;
  logic             out_ready;
  logic [BLK_W-1:0] pt;
  logic             busy;

  modport master (
    output in_valid, key, ct, out_ready,
    input  in_ready, out_valid, pt, busy
  );

  modport slave (
    input  in_valid, key, ct, out_ready,
    output in_ready, out_valid, pt, busy
  );
endinterface

// File: rtl/aes128_dec_iter.sv
// Iterative AES-128 inverse cipher, one round per clock.
// Expands forward to rk10, then rebuilds earlier round keys on the fly while decrypting.
module aes128_dec_iter #(
  parameter bit KEY_CACHE = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  aes128_dec_iter_if.slave bus
);
  localparam int unsigned BLK_W = 128;
  localparam int unsigned CNT_W = 4;
  localparam logic [7:0]  RCON_FIRST = 8'h01;
  localparam logic [7:0]  RCON_LAST  = 8'h36;

  typedef enum logic [1:0] {IDLE, KEYEXP, DEC, DONE} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] inv_xtime(input logic [7:0] x);
    return x[0] ? (((x ^ 8'h1b) >> 1) | 8'h80) : (x >> 1);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8); maps 0 to 0 without a special case
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = a;
    for (int i = 0; i < 6; i++) r = gf_mul(gf_mul(r, r), a);
    return gf_mul(r, r);
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] x);
    return {x[6:0], x[7]};
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    logic [7:0] r1;
    logic [7:0] r2;
    logic [7:0] r3;
    b  = gf_inv(a);
    r1 = rotl1(b);
    r2 = rotl1(r1);
    r3 = rotl1(r2);
    return b ^ r1 ^ r2 ^ r3 ^ rotl1(r3) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] r1;
    logic [7:0] r3;
    logic [7:0] r6;
    r1 = rotl1(s);
    r3 = rotl1(rotl1(r1));
    r6 = rotl1(rotl1(rotl1(r3)));
    return gf_inv(r1 ^ r3 ^ r6 ^ 8'h05);
  endfunction

  // byte n of a block lives at [120-8n +: 8]; n = row + 4*col
  function automatic logic [BLK_W-1:0] inv_shift_sub(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[120 - 8*(r + 4*c) +: 8] = inv_sbox(s[120 - 8*(r + 4*((c - r + 4) % 4)) +: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [BLK_W-1:0] inv_mix(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[120 - 32*c +: 8];
      a1 = s[112 - 32*c +: 8];
      a2 = s[104 - 32*c +: 8];
      a3 = s[96  - 32*c +: 8];
      o[120 - 32*c +: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[112 - 32*c +: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[104 - 32*c +: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[96  - 32*c +: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [BLK_W-1:0] key_fwd(input logic [BLK_W-1:0] rk, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = rk[127:96] ^ sub_rot_word(rk[31:0]) ^ {rc, 24'h000000};
    n1 = rk[95:64] ^ n0;
    n2 = rk[63:32] ^ n1;
    n3 = rk[31:0]  ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // undo one expansion step: rc is the Rcon that produced rk
  function automatic logic [BLK_W-1:0] key_rev(input logic [BLK_W-1:0] rk, input logic [7:0] rc);
    logic [31:0] p0, p1, p2, p3;
    p3 = rk[31:0]  ^ rk[63:32];
    p2 = rk[63:32] ^ rk[95:64];
    p1 = rk[95:64] ^ rk[127:96];
    p0 = rk[127:96] ^ sub_rot_word(p3) ^ {rc, 24'h000000};
    return {p0, p1, p2, p3};
  endfunction

  state_t           state;
  logic [BLK_W-1:0] rk;
  logic [BLK_W-1:0] data;
  logic [BLK_W-1:0] pt_q;
  logic [BLK_W-1:0] cache_key;
  logic [BLK_W-1:0] cache_rk10;
  logic             cache_valid;
  logic             out_valid_q;
  logic             in_ready_q;
  logic             busy_q;
  logic [7:0]       rcon;
  logic [CNT_W-1:0] kcnt;
  logic [CNT_W-1:0] round;

  logic [BLK_W-1:0] rk_next;
  logic [BLK_W-1:0] rk_prev;
  logic [BLK_W-1:0] last_out;
  logic [BLK_W-1:0] round_out;
  logic             cache_hit;

  // round datapath and key schedule in both directions
  always_comb begin
    rk_next   = key_fwd(rk, rcon);
    rk_prev   = key_rev(rk, rcon);
    last_out  = inv_shift_sub(data) ^ rk_prev;
    round_out = inv_mix(last_out);
    cache_hit = KEY_CACHE && cache_valid && (bus.key == cache_key);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      rk          <= '0;
      data        <= '0;
      pt_q        <= '0;
      cache_key   <= '0;
      cache_rk10  <= '0;
      cache_valid <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      rcon        <= RCON_FIRST;
      kcnt        <= '0;
      round       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (cache_hit) begin
              data  <= bus.ct ^ cache_rk10;
              rk    <= cache_rk10;
              rcon  <= RCON_LAST;
              round <= CNT_W'(9);
              state <= DEC;
            end else begin
              // data holds the ciphertext until rk10 is ready
              data        <= bus.ct;
              rk          <= bus.key;
              rcon        <= RCON_FIRST;
              kcnt        <= CNT_W'(1);
              cache_key   <= bus.key;
              cache_valid <= 1'b0;
              state       <= KEYEXP;
            end
          end
        end
        KEYEXP: begin
          rk <= rk_next;
          if (kcnt == CNT_W'(10)) begin
            cache_rk10  <= rk_next;
            cache_valid <= 1'b1;
            data        <= data ^ rk_next;
            rcon        <= RCON_LAST;
            round       <= CNT_W'(9);
            state       <= DEC;
          end else begin
            rcon <= xtime(rcon);
            kcnt <= kcnt + CNT_W'(1);
          end
        end
        DEC: begin
          if (round == '0) begin
            pt_q        <= last_out;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            data  <= round_out;
            rk    <= rk_prev;
            rcon  <= inv_xtime(rcon);
            round <= round - CNT_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.pt        = pt_q;
  assign bus.busy      = busy_q;
endmodule
